// File: rtl/mux_scan_sampler_if.sv
// Bus between the scan controller and whatever drives/observes it:
// start request, mux output feedback, select drive and the scan result.
interface mux_scan_sampler_if #(
    parameter int N = 4
);
    localparam int SEL_W = $clog2(N);

    logic             start;
    logic             y;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N-1:0]     data;

    modport master (
        output start,
        output y,
        input  sel,
        input  busy,
        input  done,
        input  data
    );

    modport slave (
        input  start,
        input  y,
        output sel,
        output busy,
        output done,
        output data
    );
endinterface

// File: rtl/mux_scan_sampler.sv
// Walks an N-to-1 mux select through every channel, waits SETTLE extra cycles
// on each, samples the mux output and publishes the assembled word atomically.
module mux_scan_sampler #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               n_reset,
    mux_scan_sampler_if.slave  bus
);
    localparam int               SEL_W  = $clog2(N);
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(N - 1);
    localparam logic [3:0]       RELOAD = 4'(SETTLE);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] chan, chan_nxt;
    logic [3:0]       wait_cnt, wait_nxt;
    logic [N-1:0]     shadow, shadow_nxt;
    logic [N-1:0]     data_q, data_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            chan     <= '0;
            wait_cnt <= '0;
            shadow   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            chan     <= chan_nxt;
            wait_cnt <= wait_nxt;
            shadow   <= shadow_nxt;
            data_q   <= data_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        chan_nxt   = chan;
        wait_nxt   = wait_cnt;
        shadow_nxt = shadow;
        data_nxt   = data_q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = SCAN;
                    chan_nxt   = '0;
                    wait_nxt   = RELOAD;
                    shadow_nxt = '0;
                end
            end
            SCAN: begin
                if (wait_cnt != 4'd0) begin
                    wait_nxt = wait_cnt - 4'd1;
                end else begin
                    shadow_nxt[chan] = bus.y;
                    if (chan != LAST) begin
                        chan_nxt = chan + 1'b1;
                        wait_nxt = RELOAD;
                    end else begin
                        // Last channel goes straight into data so the word updates in one edge.
                        data_nxt        = shadow;
                        data_nxt[N-1]   = bus.y;
                        done_nxt        = 1'b1;
                        chan_nxt        = '0;
                        state_nxt       = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.sel  = chan;
    assign bus.busy = (state == SCAN);
    assign bus.done = done_q;
    assign bus.data = data_q;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench: three sampler instances (N=4/SETTLE=1, N=4/SETTLE=0,
// N=3/SETTLE=2), each closing the loop through a modelled mux y = x[sel].
module tb_mux_scan_sampler;
    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    mux_scan_sampler_if #(.N(4)) bus_a ();
    mux_scan_sampler_if #(.N(4)) bus_b ();
    mux_scan_sampler_if #(.N(3)) bus_c ();

    logic [3:0] xa, xb;
    logic [2:0] xc;
    assign bus_a.y = xa[bus_a.sel];
    assign bus_b.y = xb[bus_b.sel];
    assign bus_c.y = xc[bus_c.sel];

    mux_scan_sampler #(.N(4), .SETTLE(1)) dut_a (.clk(clk), .n_reset(n_reset), .bus(bus_a.slave));
    mux_scan_sampler #(.N(4), .SETTLE(0)) dut_b (.clk(clk), .n_reset(n_reset), .bus(bus_b.slave));
    mux_scan_sampler #(.N(3), .SETTLE(2)) dut_c (.clk(clk), .n_reset(n_reset), .bus(bus_c.slave));

    int errors = 0;
    int checks = 0;
    int done_cnt;
    int lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance A and wait (bounded) for its done pulse.
    task automatic scan_a(input int exp_lat, input logic [3:0] exp_data, input string tag);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        lat = 0;
        while (bus_a.done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_data"}, bus_a.data, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset     = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        xa = 4'b1101;
        xb = 4'b0110;
        xc = 3'b101;
        repeat (3) tick();

        chk("rst_sel", bus_a.sel, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_data", bus_a.data, 0);
        chk("rst_data_b", bus_b.data, 0);
        chk("rst_data_c", bus_c.data, 0);
        n_reset = 1'b1;
        tick();

        // N=4, SETTLE=1: each select held two cycles, done 8 cycles after E0
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("a_sel_step", bus_a.sel, j / 2);
            chk("a_busy_scan", bus_a.busy, 1);
            chk("a_done_early", bus_a.done, 0);
            tick();
        end
        chk("a_done", bus_a.done, 1);
        chk("a_busy_end", bus_a.busy, 0);
        chk("a_sel_end", bus_a.sel, 0);
        chk("a_data", bus_a.data, 4'b1101);
        tick();
        chk("a_done_one_cycle", bus_a.done, 0);
        chk("a_data_hold", bus_a.data, 4'b1101);

        // start re-pulsed three cycles into a scan must be ignored
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        done_cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            bus_a.start = (j == 3);
            tick();
            if (bus_a.done === 1'b1) done_cnt++;
        end
        bus_a.start = 1'b0;
        chk("nb_done_on_time", bus_a.done, 1);
        chk("nb_done_count", done_cnt, 1);
        chk("nb_data", bus_a.data, 4'b1101);

        // start in the done cycle launches the next scan immediately
        xa = 4'b1011;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("b2b_busy", bus_a.busy, 1);
        chk("b2b_done_low", bus_a.done, 0);
        done_cnt = 0;
        for (int j = 1; j < 8; j++) begin
            chk("b2b_data_hold", bus_a.data, 4'b1101);
            tick();
            if (bus_a.done === 1'b1) done_cnt++;
        end
        tick();
        chk("b2b_done", bus_a.done, 1);
        chk("b2b_data", bus_a.data, 4'b1011);
        chk("b2b_no_early_done", done_cnt, 0);
        done_cnt = 0;
        repeat (10) begin
            tick();
            if (bus_a.done === 1'b1) done_cnt++;
        end
        chk("no_queued_scan", done_cnt, 0);
        chk("idle_busy", bus_a.busy, 0);

        // asynchronous reset between edges while sel == 2
        xa = 4'b1101;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (4) tick();
        chk("mid_sel_before_rst", bus_a.sel, 2);
        chk("mid_busy_before_rst", bus_a.busy, 1);
        #3;
        n_reset = 1'b0;
        #1;
        chk("arst_sel", bus_a.sel, 0);
        chk("arst_busy", bus_a.busy, 0);
        chk("arst_done", bus_a.done, 0);
        chk("arst_data", bus_a.data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            tick();
            if (bus_a.done === 1'b1) done_cnt++;
        end
        chk("arst_no_done", done_cnt, 0);
        chk("arst_idle_busy", bus_a.busy, 0);
        scan_a(8, 4'b1101, "post_rst");

        // x changes after channel 0 is sampled: only later channels see it
        tick();
        xa = 4'b0000;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
        xa = 4'b1111;
        lat = 2;
        while (bus_a.done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        chk("xchg_latency", lat, 8);
        chk("xchg_data", bus_a.data, 4'b1110);

        // N=4, SETTLE=0: one channel per cycle, busy exactly four cycles
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("s0_sel_step", bus_b.sel, j);
            chk("s0_busy", bus_b.busy, 1);
            chk("s0_done_early", bus_b.done, 0);
            tick();
        end
        chk("s0_done", bus_b.done, 1);
        chk("s0_busy_end", bus_b.busy, 0);
        chk("s0_data", bus_b.data, 4'b0110);

        // N=3, SETTLE=2: select stays within 0..2, done after nine cycles
        bus_c.start = 1'b1;
        tick();
        bus_c.start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            chk("n3_sel_step", bus_c.sel, j / 3);
            chk("n3_busy", bus_c.busy, 1);
            tick();
        end
        chk("n3_done", bus_c.done, 1);
        chk("n3_sel_end", bus_c.sel, 0);
        chk("n3_data", bus_c.data, 3'b101);
        tick();
        chk("n3_done_one_cycle", bus_c.done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
